// File: rtl/sdram_burst_sched.sv
// Arbitrates SDRAM burst requests between a write FIFO drain and a read FIFO fill.
// Tracks stored bursts in a circular SDRAM buffer, with round-robin arbitration and a request timeout.
module sdram_burst_sched #(
  parameter int          INIT_CYCLES = 50000,
  parameter int          BURST_LEN   = 8,
  parameter logic [18:0] ADDR_END    = 19'h7FFFF,
  parameter int          FIFO_DEPTH  = 256,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        i_clk_100m,
  input  logic        i_rst,
  input  logic [8:0]  i_wrf_usedw,
  input  logic [8:0]  i_rdf_usedw,
  input  logic        i_rd_en,
  input  logic        i_sdram_wr_ack,
  input  logic        i_sdram_rd_ack,
  output logic        o_sdram_wr_req,
  output logic        o_sdram_rd_req,
  output logic [21:0] o_sys_addr,
  output logic        o_init_done,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_err
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [INIT_W-1:0] L_INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [TO_W-1:0]   L_TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [8:0]        L_BURST     = 9'(BURST_LEN);
  localparam logic [8:0]        L_RD_MAX    = 9'(FIFO_DEPTH - BURST_LEN);
  localparam logic [19:0]       L_CAP       = {1'b0, ADDR_END} + 20'd1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_REQ, S_WR_BUSY, S_RD_REQ, S_RD_BUSY
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [INIT_W-1:0]   r_init_cnt, w_init_cnt_nxt;
  logic [TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
  logic [18:0]         r_wr_addr, w_wr_addr_nxt;
  logic [18:0]         r_rd_addr, w_rd_addr_nxt;
  logic [19:0]         r_fill_cnt, w_fill_nxt;
  logic                r_last_wr, w_last_wr_nxt;
  logic                r_ack_d;
  logic [21:0]         r_sys_addr, w_sys_addr_nxt;
  logic                r_wr_req, r_rd_req;
  logic                r_init_done, w_init_done_nxt;
  logic                r_full, r_empty;
  logic                r_err, w_err_nxt;
  logic                w_wr_elig, w_rd_elig, w_ack_sel, w_ack_fall;

  assign w_wr_elig  = (i_wrf_usedw >= L_BURST) && (r_fill_cnt < L_CAP);
  assign w_rd_elig  = i_rd_en && (r_fill_cnt != 20'd0) && (i_rdf_usedw <= L_RD_MAX);
  // Only the granted side's ack is ever looked at; the other one is ignored.
  assign w_ack_sel  = ((r_state == S_RD_REQ) || (r_state == S_RD_BUSY)) ? i_sdram_rd_ack
                                                                       : i_sdram_wr_ack;
  assign w_ack_fall = r_ack_d & ~w_ack_sel;

  // Next-state, pointer and bookkeeping logic
  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_to_cnt_nxt    = r_to_cnt;
    w_wr_addr_nxt   = r_wr_addr;
    w_rd_addr_nxt   = r_rd_addr;
    w_fill_nxt      = r_fill_cnt;
    w_last_wr_nxt   = r_last_wr;
    w_sys_addr_nxt  = r_sys_addr;
    w_init_done_nxt = r_init_done;
    w_err_nxt       = r_err;
    case (r_state)
      S_INIT: begin
        if (r_init_cnt == L_INIT_LAST) begin
          w_state_nxt     = S_IDLE;
          w_init_done_nxt = 1'b1;
        end else begin
          w_init_cnt_nxt = r_init_cnt + {{(INIT_W-1){1'b0}}, 1'b1};
        end
      end
      S_IDLE: begin
        w_to_cnt_nxt = '0;
        if (w_wr_elig && (!w_rd_elig || !r_last_wr)) begin
          w_state_nxt    = S_WR_REQ;
          w_sys_addr_nxt = {r_wr_addr, 3'b000};
          w_last_wr_nxt  = 1'b1;
        end else if (w_rd_elig) begin
          w_state_nxt    = S_RD_REQ;
          w_sys_addr_nxt = {r_rd_addr, 3'b000};
          w_last_wr_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_REQ, S_RD_REQ: begin
        if (w_ack_sel) begin
          w_state_nxt = (r_state == S_WR_REQ) ? S_WR_BUSY : S_RD_BUSY;
        end else if (r_to_cnt == L_TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      S_WR_BUSY: begin
        if (w_ack_fall) begin
          w_state_nxt   = S_IDLE;
          w_wr_addr_nxt = (r_wr_addr == ADDR_END) ? 19'd0 : r_wr_addr + 19'd1;
          w_fill_nxt    = r_fill_cnt + 20'd1;
        end else begin
          w_state_nxt = S_WR_BUSY;
        end
      end
      S_RD_BUSY: begin
        if (w_ack_fall) begin
          w_state_nxt   = S_IDLE;
          w_rd_addr_nxt = (r_rd_addr == ADDR_END) ? 19'd0 : r_rd_addr + 19'd1;
          w_fill_nxt    = r_fill_cnt - 20'd1;
        end else begin
          w_state_nxt = S_RD_BUSY;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // State and registered outputs; flags are derived from the next-state values
  always_ff @(posedge i_clk_100m) begin
    if (i_rst) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_to_cnt    <= '0;
      r_wr_addr   <= 19'd0;
      r_rd_addr   <= 19'd0;
      r_fill_cnt  <= 20'd0;
      r_last_wr   <= 1'b0;
      r_ack_d     <= 1'b0;
      r_sys_addr  <= 22'd0;
      r_wr_req    <= 1'b0;
      r_rd_req    <= 1'b0;
      r_init_done <= 1'b0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_last_wr   <= w_last_wr_nxt;
      r_ack_d     <= w_ack_sel;
      r_sys_addr  <= w_sys_addr_nxt;
      r_wr_req    <= (w_state_nxt == S_WR_REQ);
      r_rd_req    <= (w_state_nxt == S_RD_REQ);
      r_init_done <= w_init_done_nxt;
      r_full      <= (w_fill_nxt == L_CAP);
      r_empty     <= (w_fill_nxt == 20'd0);
      r_err       <= w_err_nxt;
    end
  end

  assign o_sdram_wr_req = r_wr_req;
  assign o_sdram_rd_req = r_rd_req;
  assign o_sys_addr     = r_sys_addr;
  assign o_init_done    = r_init_done;
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_err          = r_err;

endmodule
